parity_rr_arbiter: RTL
======================

# parity_rr_arbiter

- Shares one 4-bit parity calculator between NREQ requesters using round-robin arbitration.
- Each requester presents a nibble with a request. The arbiter grants one requester, captures its nibble, computes the even and odd parity bits, and returns the result with the requester ID over a valid/ready output port.
- It sits between the nibble-producing front ends and the framing logic that appends parity.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester ID

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; level, held until granted
- data_in  in  4*NREQ  requester i nibble on [4i+3:4i]
- gnt  out  NREQ  one-hot, one-cycle pulse; the nibble was captured at this edge
- busy  out  1  high in CALC and HOLD
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_id  out  IDW  index of the granted requester
- out_data  out  4  captured nibble
- out_even  out  1  XOR of out_data bits (even-parity bit)
- out_odd  out  1  ~out_even

## Operation

- FSM states: IDLE, CALC, HOLD. Reset state is IDLE.
- **IDLE**:
  - If |req = 0, stay in IDLE.
  - Otherwise pick the first set req[k], scanning k = ptr, ptr+1, … mod NREQ.
  - Register gnt = 1<<k, operand = data_in[k], id = k. Go to CALC.
- **CALC**:
  - gnt = 0.
  - Register out_data = operand, out_id = id, out_even = ^operand, out_odd = ~^operand, out_valid = 1. Go to HOLD.
- **HOLD**:
  - Outputs stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid = 0, ptr = (id+1) mod NREQ, go to IDLE.
- Round-robin pointer:
  - ptr resets to 0 and advances only when a result handshake completes.
  - The last-served requester has the lowest priority in the next arbitration.
- Requesters may drop req before they are granted. Arbitration looks only at req in the IDLE cycle.
- req asserted during CALC or HOLD is ignored until the next IDLE cycle. No request is lost as long as it is still held then.
- A requester whose req is still high after its gnt is treated as a new request.
- NREQ that is not a power of two: pointer wrap uses explicit compare-to-NREQ-1, not truncation.
- Reset while CALC or HOLD is active: the transaction is discarded and no result is produced. Outputs return to reset values immediately (asynchronous).

## Timing

- Reset values: gnt=0, busy=0, out_valid=0, out_id=0, out_data=0, out_even=0, out_odd=0, ptr=0, state=IDLE.
- Latency:
  - req sampled high at edge E0 (state IDLE): gnt is high during E0..E1.
  - out_valid rises at E1 and is visible in the cycle after the gnt pulse.
- Throughput with out_ready held high:
  - One result every 3 cycles (IDLE, CALC, HOLD).
  - The handshake occurs in the first HOLD cycle.
- out_even, out_odd, out_data and out_id change only at the CALC→HOLD edge. They hold their value after the handshake until the next CALC.
- gnt is never high for more than one cycle, and never for more than one requester.
- busy is 1 exactly while state ≠ IDLE.

## Structure

- Package parity_arb_pkg:
  - state enum {IDLE, CALC, HOLD}
  - NIBBLE_W = 4
  - NREQ_DEFAULT = 4
- Sub-module parity_calc4: purely combinational, nibble → even/odd bits. Instantiated once on the operand register.
- The round-robin pick is a function or always_comb block inside the top level. No separate module.

## Test plan

- **Single request.** Reset, then req=4'b0010 with data_in[7:4]=4'b1011.
  - gnt=4'b0010 for one cycle.
  - Next cycle: out_valid=1, out_id=1, out_data=4'b1011, out_even=1, out_odd=0.
- **All four request, out_ready=1.** Nibbles are 0000, 0001, 0011, 0111.
  - Grants in order 0,1,2,3, one every 3 cycles.
  - out_even sequence: 0, 1, 0, 1.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid.
  - Outputs are stable for those 5 cycles and no gnt is issued.
  - The handshake happens in the cycle out_ready=1, and state returns to IDLE.
- **Fairness.** Requester 2 is just served; req=4'b0101 remains.
  - Next grant goes to 0 (scan from ptr=3 wraps to 0), then to 2.
- **Reset mid-operation.** Assert rst_n=0 while in HOLD with out_valid=1.
  - All outputs go to 0 at once.
  - After release, req=4'b1000 is granted to 3 with ptr at 0.
- **Withdrawn request.** Requester 1 drops req during another requester's HOLD.
  - It receives no gnt and produces no result.

Source files
------------

// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the round-robin parity arbiter.
package parity_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int NIBBLE_W     = 4;
  localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/parity_calc4.sv
// Combinational even/odd parity of one nibble.
module parity_calc4
  import parity_arb_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic                even_o,
  output logic                odd_o
);

  assign even_o = ^nibble_i;
  assign odd_o  = ~even_o;

endmodule

// File: rtl/parity_rr_arbiter.sv
// Round-robin arbiter sharing one nibble parity calculator between NREQ requesters.
// Output handshake: a result transfers on any rising edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_id/out_data/out_even/out_odd hold.
module parity_rr_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NIBBLE_W*NREQ-1:0] data_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDW-1:0]           out_id,
  output logic [NIBBLE_W-1:0]      out_data,
  output logic                     out_even,
  output logic                     out_odd
);

  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW:0]    LAST_W  = (IDW + 1)'(NREQ - 1);
  localparam logic [IDW:0]    NREQ_W  = (IDW + 1)'(NREQ);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NIBBLE_W-1:0] operand_q, operand_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                out_valid_q, out_valid_d;
  logic [IDW-1:0]      out_id_q, out_id_d;
  logic [NIBBLE_W-1:0] out_data_q, out_data_d;
  logic                out_even_q, out_even_d;
  logic                out_odd_q, out_odd_d;

  logic                calc_even, calc_odd;
  logic                pick_found;
  logic [IDW-1:0]      pick_idx;
  logic [IDW:0]        cand;

  parity_calc4 u_calc (
    .nibble_i (operand_q),
    .even_o   (calc_even),
    .odd_o    (calc_odd)
  );

  // Scan from ptr upward with wrap; iterating offsets high-to-low lets the nearest hit win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + (IDW + 1)'(off);
      if (cand > LAST_W) cand = cand - NREQ_W;
      if (req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    operand_d   = operand_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    out_even_d  = out_even_q;
    out_odd_d   = out_odd_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d     = GNT_ONE << pick_idx;
          operand_d = data_in[int'(pick_idx) * NIBBLE_W +: NIBBLE_W];
          id_d      = pick_idx;
          state_d   = CALC;
        end
      end
      CALC: begin
        out_data_d  = operand_q;
        out_id_d    = id_q;
        out_even_d  = calc_even;
        out_odd_d   = calc_odd;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
          ptr_d       = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      operand_q   <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_even_q  <= 1'b0;
      out_odd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      operand_q   <= operand_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign out_even  = out_even_q;
  assign out_odd   = out_odd_q;

endmodule
